// File: rtl/segscan_spi_ctrl.sv
// segscan_spi_ctrl: SPI-written N-digit 7-segment display scanner that also
// scans a shared keypad matrix, debounces it and returns the lowest pressed
// key on MISO. All SPI pins are oversampled on clk.
// Build option: define SEGSCAN_DP_EN to make frame bit 7 a decimal point
// (adds port seg_dp_n) instead of a blank flag.
module segscan_spi_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int KEY_COLS    = 4,
    parameter int REFRESH_DIV = 1024,
    parameter int DEBOUNCE    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  spi_sck,
    input  logic                  spi_mosi,
    input  logic                  spi_en,
    output logic                  spi_miso,
    output logic                  miso_oe_n,
    input  logic [KEY_COLS-1:0]   key_col,
    output logic [6:0]            seg_n,
`ifdef SEGSCAN_DP_EN
    output logic                  seg_dp_n,
`endif
    output logic [NUM_DIGITS-1:0] dig_sel_n,
    output logic                  frame_err
);
    localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW = $clog2(REFRESH_DIV);
    localparam int NK = NUM_DIGITS * KEY_COLS;
    localparam int CW = $clog2(DEBOUNCE + 1);

    function automatic logic [6:0] font(input logic [3:0] v);
        case (v)
            4'h0: font = 7'h7E;
            4'h1: font = 7'h30;
            4'h2: font = 7'h6D;
            4'h3: font = 7'h79;
            4'h4: font = 7'h33;
            4'h5: font = 7'h5B;
            4'h6: font = 7'h5F;
            4'h7: font = 7'h70;
            4'h8: font = 7'h7F;
            4'h9: font = 7'h7B;
            4'hA: font = 7'h77;
            4'hB: font = 7'h1F;
            4'hC: font = 7'h4E;
            4'hD: font = 7'h3D;
            4'hE: font = 7'h4F;
            default: font = 7'h47;
        endcase
    endfunction

    // ---------------- input synchronisers ----------------
    logic                sck_m_q, sck_s_q, sck_p_q;
    logic                en_m_q, en_s_q, en_p_q;
    logic                mosi_m_q, mosi_s_q;
    logic [KEY_COLS-1:0] key_m_q, key_s_q;
    logic                sck_rise, sck_fall, en_rise, en_fall;

    // Two-flop synchronisers plus a delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sck_m_q  <= 1'b0;
            sck_s_q  <= 1'b0;
            sck_p_q  <= 1'b0;
            en_m_q   <= 1'b0;
            en_s_q   <= 1'b0;
            en_p_q   <= 1'b0;
            mosi_m_q <= 1'b0;
            mosi_s_q <= 1'b0;
            key_m_q  <= '0;
            key_s_q  <= '0;
        end else begin
            sck_m_q  <= spi_sck;
            sck_s_q  <= sck_m_q;
            sck_p_q  <= sck_s_q;
            en_m_q   <= spi_en;
            en_s_q   <= en_m_q;
            en_p_q   <= en_s_q;
            mosi_m_q <= spi_mosi;
            mosi_s_q <= mosi_m_q;
            key_m_q  <= key_col;
            key_s_q  <= key_m_q;
        end
    end

    assign sck_rise = sck_s_q & ~sck_p_q;
    assign sck_fall = ~sck_s_q & sck_p_q;
    assign en_rise  = en_s_q & ~en_p_q;
    assign en_fall  = ~en_s_q & en_p_q;

    // ---------------- SPI frame engine ----------------
    logic [7:0] rx_q, rx_d, tx_q, tx_d, status;
    logic [3:0] cnt_q, cnt_d;
    logic       err_q, err_d, commit, wr_ok;
    logic [SW-1:0] wr_sel;

    assign wr_ok  = ({1'b0, rx_q[6:4]} < 4'(NUM_DIGITS));
    assign wr_sel = rx_q[SW+3:4];

    // Next-state for shift registers, bit count, sticky error and commit strobe
    always_comb begin
        rx_d   = rx_q;
        tx_d   = tx_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        commit = 1'b0;
        if (en_rise) begin
            cnt_d = '0;
            tx_d  = status;
        end else if (en_s_q) begin
            if (sck_rise) begin
                rx_d = {rx_q[6:0], mosi_s_q};
                if (cnt_q != 4'd9) cnt_d = cnt_q + 4'd1;
            end
            if (sck_fall) tx_d = {tx_q[6:0], 1'b0};
        end
        if (en_fall) begin
            if (cnt_q == 4'd8) commit = wr_ok;
            else               err_d  = 1'b1;
        end
    end

    // Frame engine registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_q  <= '0;
            tx_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            rx_q  <= rx_d;
            tx_q  <= tx_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign spi_miso  = tx_q[7];
    assign miso_oe_n = ~en_s_q;
    assign frame_err = err_q;

    // ---------------- display register file ----------------
    logic [NUM_DIGITS-1:0]      blank_q;
    logic [NUM_DIGITS-1:0][3:0] val_q;
`ifdef SEGSCAN_DP_EN
    logic [NUM_DIGITS-1:0]      dp_q;
`endif

    // Digit entries, written by committed in-range frames
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blank_q <= '1;
            val_q   <= '0;
`ifdef SEGSCAN_DP_EN
            dp_q    <= '0;
`endif
        end else if (commit) begin
            val_q[wr_sel]   <= rx_q[3:0];
`ifdef SEGSCAN_DP_EN
            dp_q[wr_sel]    <= rx_q[7];
            blank_q[wr_sel] <= 1'b0;
`else
            blank_q[wr_sel] <= rx_q[7];
`endif
        end
    end

    // ---------------- scanner and debounce ----------------
    logic [DW-1:0] div_q, div_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [NK-1:0] raw_q, raw_d, prev_q, prev_d, deb_q, deb_d;
    logic [CW-1:0] stab_q, stab_d;

    // Divider/slot walk, column capture at slot end, full-matrix debounce at wrap
    always_comb begin
        div_d  = div_q + DW'(1);
        slot_d = slot_q;
        raw_d  = raw_q;
        prev_d = prev_q;
        deb_d  = deb_q;
        stab_d = stab_q;
        if (div_q == DW'(REFRESH_DIV - 1)) begin
            div_d = '0;
            raw_d[slot_q*KEY_COLS +: KEY_COLS] = key_s_q;
            if (slot_q == SW'(NUM_DIGITS - 1)) begin
                slot_d = '0;
                prev_d = raw_d;
                if (raw_d == prev_q) begin
                    if (stab_q != CW'(DEBOUNCE)) stab_d = stab_q + CW'(1);
                end else begin
                    stab_d = CW'(1);
                end
                if (stab_d == CW'(DEBOUNCE)) deb_d = raw_d;
            end else begin
                slot_d = slot_q + SW'(1);
            end
        end
    end

    // Scanner and debounce registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q  <= '0;
            slot_q <= '0;
            raw_q  <= '0;
            prev_q <= '0;
            deb_q  <= '0;
            stab_q <= '0;
        end else begin
            div_q  <= div_d;
            slot_q <= slot_d;
            raw_q  <= raw_d;
            prev_q <= prev_d;
            deb_q  <= deb_d;
            stab_q <= stab_d;
        end
    end

    // Status byte: lowest set bit of the debounced matrix, row-major
    logic found;
    always_comb begin
        status = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < NK; i++) begin
            if (deb_q[i] && !found) begin
                found  = 1'b1;
                status = {1'b1, 7'(i)};
            end
        end
    end

    // ---------------- output registers ----------------
    logic [6:0]            seg_d;
    logic [NUM_DIGITS-1:0] sel_d;
    logic                  blanking;
`ifdef SEGSCAN_DP_EN
    logic                  dp_n_d;
`endif

    assign blanking = (div_q < DW'(2));

    // Segment, digit-select and decimal-point values for the current slot
    always_comb begin
        seg_d = blank_q[slot_q] ? 7'h7F : ~font(val_q[slot_q]);
        sel_d = '1;
        if (!blanking) sel_d[slot_q] = 1'b0;
`ifdef SEGSCAN_DP_EN
        dp_n_d = (blanking || blank_q[slot_q]) ? 1'b1 : ~dp_q[slot_q];
`endif
    end

    // Registered display outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_n     <= 7'h7F;
            dig_sel_n <= '1;
`ifdef SEGSCAN_DP_EN
            seg_dp_n  <= 1'b1;
`endif
        end else begin
            seg_n     <= seg_d;
            dig_sel_n <= sel_d;
`ifdef SEGSCAN_DP_EN
            seg_dp_n  <= dp_n_d;
`endif
        end
    end

endmodule
